// File: rtl/tx_frame_if.sv
// Valid/ready link between the transmit stage and the receiver, with the shared busy qualifier.
// The master drives the word; the slave answers with ready and owns busy.
interface tx_frame_if #(
    parameter int DATA_W = 3
);
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              ready;
    logic              busy;

    modport master (output valid, output data, input ready, input busy);
    modport slave  (input valid, input data, output ready, output busy);
endinterface

// File: rtl/tx_frame.sv
// Transmit stage: a small FIFO feeding a valid/ready link, holding each word until accepted
// and never launching a new word while the link reports busy.
module tx_frame #(
    parameter int DATA_W = 3,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en_i,
    input  logic [DATA_W-1:0]          wr_data_i,
    output logic                       full_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       ovf_o,
    output logic [7:0]                 sent_cnt_o,
    tx_frame_if.master                 link
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [7:0]        sent_q, sent_d;

    logic full, launch, xfer, push, pop;

    // Full is taken from the registered count, so a write while full is lost even if a pop frees a slot.
    assign full   = (count_q == CW'(DEPTH));
    assign launch = (count_q != '0) && !link.busy;
    assign xfer   = valid_q && link.ready;
    assign push   = wr_en_i && !full;
    assign pop    = launch && ((state_q == IDLE) || xfer);

    always_comb begin
        state_d  = state_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        ovf_d    = ovf_q | (wr_en_i & full);
        valid_d  = valid_q;
        data_d   = data_q;
        sent_d   = sent_q;

        if (push) begin
            mem_d[wr_ptr_q] = wr_data_i;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            data_d   = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (xfer) begin
            sent_d = sent_q + 8'd1;
        end

        // Once valid, a word is only retired by a transfer; busy merely blocks the next launch.
        case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d = SEND;
                    valid_d = 1'b1;
                end
            end
            SEND: begin
                if (xfer && !launch) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            sent_q   <= '0;
        end else begin
            state_q  <= state_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            sent_q   <= sent_d;
        end
    end

    assign full_o     = full;
    assign count_o    = count_q;
    assign ovf_o      = ovf_q;
    assign sent_cnt_o = sent_q;
    assign link.valid = valid_q;
    assign link.data  = data_q;
endmodule

// File: tb/tb_tx_frame.sv
// Scoreboard bench for tx_frame: accepted writes queue their expected word, and a monitor
// compares every link transfer against the head of that queue.
module tb_tx_frame;
    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [2:0] wr_data;
    logic       full;
    logic [2:0] count;
    logic       ovf;
    logic [7:0] sent_cnt;

    int checks = 0;
    int errors = 0;
    logic [2:0] exp_q [$];

    tx_frame_if #(.DATA_W(3)) link ();

    tx_frame #(.DATA_W(3), .DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en_i    (wr_en),
        .wr_data_i  (wr_data),
        .full_o     (full),
        .count_o    (count),
        .ovf_o      (ovf),
        .sent_cnt_o (sent_cnt),
        .link       (link.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs; a write the bench expects to be accepted queues its word.
    task automatic applyStimulus(input logic wr, input logic [2:0] d, input logic rdy,
                                 input logic bsy, input logic accept);
        wr_en      = wr;
        wr_data    = d;
        link.ready = rdy;
        link.busy  = bsy;
        if (wr && accept) exp_q.push_back(d);
        step();
    endtask

    // Inputs change just after posedge, so valid&ready at negedge predicts the next edge's transfer.
    always @(negedge clk) begin
        if (rst_n && link.valid && link.ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_xfer", 32'd1, 32'd0);
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                checkOutput("xfer_data", 32'(link.data), 32'(e));
            end
        end
    end

    initial begin
        rst_n      = 1'b1;
        wr_en      = 1'b0;
        wr_data    = '0;
        link.ready = 1'b0;
        link.busy  = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        checkOutput("rst_valid", 32'(link.valid), 0);
        checkOutput("rst_data", 32'(link.data), 0);
        checkOutput("rst_count", 32'(count), 0);
        checkOutput("rst_full", 32'(full), 0);
        checkOutput("rst_ovf", 32'(ovf), 0);
        checkOutput("rst_sent", 32'(sent_cnt), 0);
        step();
        rst_n = 1'b1;
        step();

        $display("[TB] reset during SEND");
        applyStimulus(1, 3'd6, 0, 0, 1);
        applyStimulus(1, 3'd5, 0, 0, 1);
        applyStimulus(1, 3'd4, 0, 0, 1);
        wr_en = 1'b0;
        checkOutput("midsend_valid", 32'(link.valid), 1);
        checkOutput("midsend_count", 32'(count), 2);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", 32'(link.valid), 0);
        checkOutput("async_rst_count", 32'(count), 0);
        checkOutput("async_rst_sent", 32'(sent_cnt), 0);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) applyStimulus(0, 3'd0, 1, 0, 0);
        checkOutput("post_rst_idle", 32'(link.valid), 0);

        $display("[TB] single word");
        applyStimulus(1, 3'b101, 1, 0, 1);
        wr_en = 1'b0;
        checkOutput("single_count_e0", 32'(count), 1);
        checkOutput("single_valid_e0", 32'(link.valid), 0);
        step();
        checkOutput("single_valid_e1", 32'(link.valid), 1);
        checkOutput("single_data_e1", 32'(link.data), 32'b101);
        step();
        checkOutput("single_valid_e2", 32'(link.valid), 0);
        checkOutput("single_sent", 32'(sent_cnt), 1);

        $display("[TB] back-pressure and busy");
        applyStimulus(1, 3'b001, 0, 0, 1);
        applyStimulus(1, 3'b010, 0, 0, 1);
        wr_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("hold_valid", 32'(link.valid), 1);
            checkOutput("hold_data", 32'(link.data), 32'b001);
            step();
        end
        applyStimulus(0, 3'd0, 0, 1, 0);
        applyStimulus(0, 3'd0, 1, 1, 0);
        checkOutput("busy_valid_dropped", 32'(link.valid), 0);
        checkOutput("busy_sent", 32'(sent_cnt), 2);
        step();
        checkOutput("busy_no_launch", 32'(link.valid), 0);
        checkOutput("busy_count", 32'(count), 1);
        link.busy = 1'b0;
        step();
        checkOutput("unbusy_valid", 32'(link.valid), 1);
        checkOutput("unbusy_data", 32'(link.data), 32'b010);
        step();
        checkOutput("unbusy_sent", 32'(sent_cnt), 3);

        $display("[TB] full and overflow");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 3'(i), 0, 1, (i < 4) ? 1'b1 : 1'b0);
            if (i == 3) begin
                checkOutput("full_flag", 32'(full), 1);
                checkOutput("full_count", 32'(count), 4);
                checkOutput("ovf_before", 32'(ovf), 0);
            end
        end
        wr_en = 1'b0;
        checkOutput("ovf_set", 32'(ovf), 1);
        checkOutput("ovf_count", 32'(count), 4);
        link.busy  = 1'b0;
        link.ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        step();
        checkOutput("drain_empty", 32'(exp_q.size()), 0);
        checkOutput("drain_count", 32'(count), 0);
        checkOutput("drain_sent", 32'(sent_cnt), 7);
        checkOutput("ovf_sticky", 32'(ovf), 1);

        $display("[TB] wrap stream");
        rst_n = 1'b0;
        #1;
        checkOutput("wrap_rst_ovf", 32'(ovf), 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1, 3'(i % 7), 1, 0, 1);
            checkOutput("steady_count_le1", 32'(count <= 3'd1), 1);
        end
        wr_en = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        step();
        checkOutput("wrap_empty", 32'(exp_q.size()), 0);
        checkOutput("wrap_sent", 32'(sent_cnt), 44);
        checkOutput("wrap_valid", 32'(link.valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
